// File: rtl/booth_mul_arbiter.sv
// Shares one iterative signed 8x8 Booth radix-2 multiplier between two requesters.
// A grant is issued in the IDLE cycle, then CLEAR, LOAD, STEPS x RUN and CAPTURE follow,
// so rsp_valid first rises STEPS+4 cycles after the grant. The response is held until rsp_ack.
// Ports:
//   clk, rst                 - rising-edge clock, asynchronous active-high reset
//   req0/a0/b0, req1/a1/b1   - level requests with signed operands, held until granted
//   gnt0, gnt1               - one-cycle grant pulses (operands latched on that edge)
//   rsp_valid/rsp_id/rsp_product/rsp_ack - response channel, valid held until ack
//   mul_clr/mul_load/mul_step/mul_a/mul_b - control and operands to the Booth datapath
//   mul_done/mul_product     - datapath done flag and {A,Q} product
//   busy, err                - not-IDLE indicator, sticky "done was low at capture"
module booth_mul_arbiter #(
   parameter int STEPS = 8,
   parameter int CNT_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic [7:0]  a0,
   input  logic [7:0]  b0,
   input  logic        req1,
   input  logic [7:0]  a1,
   input  logic [7:0]  b1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [15:0] rsp_product,
   input  logic        rsp_ack,
   output logic        mul_clr,
   output logic        mul_load,
   output logic        mul_step,
   output logic [7:0]  mul_a,
   output logic [7:0]  mul_b,
   input  logic        mul_done,
   input  logic [15:0] mul_product,
   output logic        busy,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOAD,
      RUN,
      CAPTURE,
      RESP
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             last;
   logic             grant;
   logic             pick1;

   // Requester 1 wins when it is alone, or when both ask and requester 0 had
   // the previous grant. Grants are masked while reset is held so every output
   // reads zero during reset even if a request is already pending.
   always_comb begin
      pick1 = req1 && (!req0 || !last);
      grant = (state == IDLE) && (req0 || req1) && !rst;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      mul_clr   = 1'b0;
      mul_load  = 1'b0;
      mul_step  = 1'b0;
      rsp_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (grant) begin
               gnt0      = !pick1;
               gnt1      = pick1;
               state_nxt = CLEAR;
            end
         end
         CLEAR: begin
            mul_clr   = 1'b1;
            state_nxt = LOAD;
         end
         LOAD: begin
            mul_load  = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            mul_step = 1'b1;
            // cnt counts completed steps; the STEPS-th step is the last RUN cycle
            if (cnt == CNT_W'(STEPS - 1)) begin
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ack) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_a       <= '0;
         mul_b       <= '0;
         rsp_id      <= 1'b0;
         rsp_product <= '0;
         err         <= 1'b0;
         cnt         <= '0;
         last        <= 1'b1;
      end else begin
         if (grant) begin
            mul_a  <= pick1 ? a1 : a0;
            mul_b  <= pick1 ? b1 : b0;
            last   <= pick1;
            rsp_id <= pick1;
         end
         if (state == LOAD) begin
            cnt <= '0;
         end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
         end
         if (state == CAPTURE) begin
            rsp_product <= mul_product;
            if (!mul_done) begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: drives both requesters, emulates a Booth radix-2
// datapath that reacts to mul_clr/mul_load/mul_step, and compares every output on
// every cycle against a transaction-level model of grant, phase and response timing.
module tb_booth_mul_arbiter;

   localparam int STEPS = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic        gnt0, gnt1, rsp_valid, rsp_id;
   logic [15:0] rsp_product;
   logic        rsp_ack = 1'b0;
   logic        mul_clr, mul_load, mul_step;
   logic [7:0]  mul_a, mul_b;
   logic        mul_done;
   logic [15:0] mul_product;
   logic        busy, err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   booth_mul_arbiter #(.STEPS(STEPS), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product), .rsp_ack(rsp_ack),
      .mul_clr(mul_clr), .mul_load(mul_load), .mul_step(mul_step),
      .mul_a(mul_a), .mul_b(mul_b),
      .mul_done(mul_done), .mul_product(mul_product),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- Booth datapath emulation ----------------
   logic [8:0] dp_a = '0;
   logic [8:0] dp_an;
   logic [7:0] dp_q = '0;
   logic       dp_qm1 = 1'b0;
   int         dp_cnt = 0;
   logic       dp_done = 1'b0;
   logic       force_done_low = 1'b0;

   always @(posedge clk) begin
      if (mul_clr) begin
         dp_cnt  <= 0;
         dp_done <= 1'b0;
      end else if (mul_load) begin
         dp_a   <= '0;
         dp_q   <= mul_b;
         dp_qm1 <= 1'b0;
      end else if (mul_step) begin
         dp_an = dp_a;
         if ({dp_q[0], dp_qm1} == 2'b01) dp_an = dp_a + {mul_a[7], mul_a};
         if ({dp_q[0], dp_qm1} == 2'b10) dp_an = dp_a - {mul_a[7], mul_a};
         dp_qm1  <= dp_q[0];
         dp_q    <= {dp_an[0], dp_q[7:1]};
         dp_a    <= {dp_an[8], dp_an[8:1]};
         dp_cnt  <= dp_cnt + 1;
         dp_done <= (dp_cnt + 1 == STEPS);
      end
   end

   assign mul_done    = dp_done && !force_done_low;
   assign mul_product = {dp_a[7:0], dp_q};

   // ---------------- transaction-level reference model ----------------
   // m_phase counts cycles since the grant: 1 clear, 2 load, 3..STEPS+2 step,
   // STEPS+3 capture, STEPS+4 onward response until acknowledged.
   logic        m_busy = 1'b0, m_last = 1'b1, m_owner = 1'b0, m_err = 1'b0;
   int          m_phase = 0;
   logic [7:0]  m_a = '0, m_b = '0;
   logic [15:0] m_prod = '0;
   logic        e_g0, e_g1, e_clr, e_load, e_step, e_valid;
   int          m_full;

   always @(negedge clk) begin
      if (rst) begin
         m_busy = 1'b0; m_phase = 0; m_last = 1'b1; m_owner = 1'b0;
         m_a = '0; m_b = '0; m_prod = '0; m_err = 1'b0;
         chk("reset_outputs",
             {23'd0, gnt0, gnt1, rsp_valid, rsp_id, rsp_product, mul_clr, mul_load,
              mul_step, mul_a, mul_b, busy, err}, 64'd0);
      end else begin
         e_g0    = !m_busy && req0 && (!req1 || m_last);
         e_g1    = !m_busy && req1 && (!req0 || !m_last);
         e_clr   = m_busy && m_phase == 1;
         e_load  = m_busy && m_phase == 2;
         e_step  = m_busy && m_phase >= 3 && m_phase <= STEPS + 2;
         e_valid = m_busy && m_phase >= STEPS + 4;
         chk("gnt", {gnt0, gnt1}, {e_g0, e_g1});
         chk("mul_ctrl", {mul_clr, mul_load, mul_step}, {e_clr, e_load, e_step});
         chk("rsp_valid", rsp_valid, e_valid);
         chk("busy", busy, m_busy);
         chk("rsp_id", rsp_id, m_owner);
         chk("rsp_product", rsp_product, m_prod);
         chk("mul_operands", {mul_a, mul_b}, {m_a, m_b});
         chk("err", err, m_err);
         if (!m_busy) begin
            if (e_g0 || e_g1) begin
               m_busy  = 1'b1;
               m_phase = 1;
               m_owner = e_g1;
               m_last  = e_g1;
               m_a     = e_g1 ? a1 : a0;
               m_b     = e_g1 ? b1 : b0;
            end
         end else begin
            if (m_phase == STEPS + 3) begin
               m_full = int'($signed(m_a)) * int'($signed(m_b));
               m_prod = m_full[15:0];
               if (!mul_done) m_err = 1'b1;
            end
            if (e_valid && rsp_ack) m_busy = 1'b0;
            else m_phase++;
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1; break; end
      end
      chk("idle_timeout", ok, 1);
   endtask

   // One operation with ack held high; literal expectations for latency, step
   // count, product and id.
   task automatic do_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_prod, input string tag);
      bit ok = 0;
      int g = 0, steps = 0;
      @(posedge clk); #1;
      rsp_ack = 1'b1;
      if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
      else    begin req0 = 1'b1; a0 = a; b0 = b; end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (id ? gnt1 : gnt0) begin ok = 1; g = cyc; break; end
      end
      chk({tag, "_gnt_seen"}, ok, 1);
      @(posedge clk); #1;
      if (id) req1 = 1'b0; else req0 = 1'b0;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mul_step) steps++;
         if (rsp_valid) begin ok = 1; break; end
      end
      chk({tag, "_rsp_seen"}, ok, 1);
      chk({tag, "_latency"}, cyc - g, STEPS + 4);
      chk({tag, "_steps"}, steps, STEPS);
      chk({tag, "_product"}, rsp_product, exp_prod);
      chk({tag, "_id"}, rsp_id, id);
      wait_idle();
   endtask

   bit          ok;
   bit          g0s, g1s;
   int          gids[4];
   int          gcyc[4];
   int          ng;
   logic [15:0] held_prod;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_idle", {busy, rsp_valid, err, mul_a, mul_b, rsp_product}, 0);
      rst = 1'b0;

      // basic products
      do_op(0, 8'd3, 8'd5, 16'h000F, "op_3x5");
      do_op(0, 8'h80, 8'h80, 16'h4000, "op_m128sq");
      do_op(1, 8'hFD, 8'd5, 16'hFFF1, "op_m3x5");

      // contention: last was 1, so grants must go 0,1,0,1 at STEPS+5 spacing
      @(posedge clk); #1;
      rsp_ack = 1'b1;
      req0 = 1'b1; a0 = 8'd11; b0 = 8'hF0;
      req1 = 1'b1; a1 = 8'h9C; b1 = 8'd7;
      ng = 0;
      for (int i = 0; i < 120 && ng < 4; i++) begin
         @(negedge clk);
         if (gnt0 || gnt1) begin gids[ng] = gnt1 ? 1 : 0; gcyc[ng] = cyc; ng++; end
      end
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      chk("rr_count", ng, 4);
      for (int i = 0; i < 4; i++) chk("rr_order", gids[i], i % 2);
      for (int i = 1; i < 4; i++) chk("rr_spacing", gcyc[i] - gcyc[i-1], STEPS + 5);
      wait_idle();

      // ack withheld: response stable, busy requester 1 not granted
      @(posedge clk); #1;
      rsp_ack = 1'b0;
      req0 = 1'b1; a0 = 8'd7; b0 = 8'hFE;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (gnt0) begin ok = 1; break; end
      end
      chk("hold_gnt0", ok, 1);
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b1; a1 = 8'd2; b1 = 8'd3;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rsp_valid) begin ok = 1; break; end
      end
      chk("hold_rsp_seen", ok, 1);
      held_prod = rsp_product;
      chk("hold_product", held_prod, 16'hFFF2);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold_stable", {rsp_valid, rsp_id, rsp_product, gnt1}, {1'b1, 1'b0, 16'hFFF2, 1'b0});
      end
      @(posedge clk); #1;
      rsp_ack = 1'b1;
      @(negedge clk);
      chk("hold_ack_cycle", rsp_valid, 1);
      @(negedge clk);
      chk("hold_then_gnt1", {rsp_valid, gnt1}, 2'b01);
      @(posedge clk); #1;
      req1 = 1'b0;
      wait_idle();

      // reset six cycles into a run
      @(posedge clk); #1;
      req0 = 1'b1; a0 = 8'd9; b0 = 8'd9;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (gnt0) begin ok = 1; break; end
      end
      chk("rst_run_gnt", ok, 1);
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      req1 = 1'b1; a1 = 8'd4; b1 = 8'd4;
      #1;
      chk("rst_immediate",
          {busy, rsp_valid, mul_step, mul_clr, mul_load, gnt0, gnt1, mul_a, mul_b}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_then_gnt0", {gnt0, gnt1}, 2'b10);
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      wait_idle();

      // randomized traffic, model checks every cycle
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         g0s = gnt0; g1s = gnt1;
         @(posedge clk); #1;
         if (req0 && g0s) req0 = 1'b0;
         else if (!req0 && $urandom_range(3) == 0) begin
            req0 = 1'b1; a0 = 8'($urandom); b0 = 8'($urandom);
         end else if (req0 && $urandom_range(40) == 0) req0 = 1'b0;
         if (req1 && g1s) req1 = 1'b0;
         else if (!req1 && $urandom_range(3) == 0) begin
            req1 = 1'b1; a1 = 8'($urandom); b1 = 8'($urandom);
         end else if (req1 && $urandom_range(40) == 0) req1 = 1'b0;
         rsp_ack = ($urandom_range(2) != 0);
      end
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0; rsp_ack = 1'b1;
      wait_idle();

      // datapath reports not-done at capture: err sticks, responses still delivered
      chk("err_before", err, 0);
      force_done_low = 1'b1;
      do_op(0, 8'h11, 8'd2, 16'h0022, "op_err");
      chk("err_set", err, 1);
      force_done_low = 1'b0;
      do_op(1, 8'hFF, 8'hFF, 16'h0001, "op_after_err");
      chk("err_sticky", err, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("err_cleared", err, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
- Control unit that shares one iterative signed 8x8 Booth radix-2 multiplier between two requesters, such as two ALU issue ports.
- Grants one requester at a time with round-robin arbitration and latches that requester's operands.
- Sequences the multiplier: clear, then load, then a fixed number of step cycles.
- Captures the 16-bit product and returns it over a valid/ack response channel tagged with the requester id.

Parameters:
- STEPS, 8, number of mul_step cycles issued per multiplication (equals operand width).
- CNT_W, 4, width of the internal step counter; must satisfy 2^CNT_W > STEPS.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous active-high reset.
- req0  input  1  requester 0 operation request; level, held until gnt0.
- a0  input  8  requester 0 multiplicand, signed two's complement.
- b0  input  8  requester 0 multiplier, signed two's complement.
- req1  input  1  requester 1 request.
- a1  input  8  requester 1 multiplicand.
- b1  input  8  requester 1 multiplier.
- gnt0  output  1  one-cycle pulse: requester 0 accepted, operands latched.
- gnt1  output  1  one-cycle pulse: requester 1 accepted.
- rsp_valid  output  1  product available.
- rsp_id  output  1  id of requester owning rsp_product.
- rsp_product  output  16  signed product.
- rsp_ack  input  1  response consumed when high with rsp_valid.
- mul_clr  output  1  one-cycle clear of the multiplier step counter/done flag.
- mul_load  output  1  one-cycle load of initial A=0, Q=mul_b, Qm1=0 (active-high).
- mul_step  output  1  iterate enable; high for exactly STEPS consecutive cycles.
- mul_a  output  8  multiplicand to datapath.
- mul_b  output  8  multiplier to datapath.
- mul_done  input  1  multiplier done flag.
- mul_product  input  16  multiplier {A,Q}.
- busy  output  1  high in any state other than IDLE.
- err  output  1  sticky: mul_done was low at capture; cleared only by rst.

Behaviour:
- Reset (async, rst=1): state=IDLE.
  - All outputs 0, including rsp_product, mul_a, mul_b and err.
  - Round-robin pointer last=1, so requester 0 wins the first contention.
- States: IDLE, CLEAR, LOAD, RUN, CAPTURE, RESP.
- IDLE, arbitration:
  - Only req0: grant 0. Only req1: grant 1.
  - Both high: grant the requester not equal to last.
  - On grant: pulse gnt_x for 1 cycle, latch a_x/b_x into mul_a/mul_b, set last=x, set rsp_id=x, go to CLEAR.
  - No request: stay in IDLE.
- CLEAR: mul_clr=1 for 1 cycle, then go to LOAD.
- LOAD: mul_load=1 for 1 cycle, clear the step counter, then go to RUN.
- RUN:
  - mul_step=1 every cycle; the counter increments each cycle.
  - After the STEPS-th step cycle, go to CAPTURE.
  - mul_step is never asserted outside RUN.
- CAPTURE, 1 cycle, mul_step=0:
  - rsp_product <= mul_product.
  - If mul_done=0, set err=1; the sequence still proceeds.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_product and rsp_id are stable.
  - Held until rsp_ack=1. On ack, rsp_valid drops the next cycle and the state returns to IDLE.
- Stability and exclusivity:
  - mul_a and mul_b hold constant from grant through CAPTURE.
  - rsp_product holds its value until the next CAPTURE.
  - mul_clr, mul_load and mul_step are mutually exclusive.
- Latency (STEPS=8), grant at cycle 0:
  - mul_clr at cycle 1, mul_load at cycle 2.
  - mul_step at cycles 3-10, capture at cycle 11.
  - rsp_valid first high at cycle 12, i.e. STEPS+4.
- Throughput: with rsp_ack held high, one result per STEPS+5 cycles; a new grant is allowed in the cycle after the ack.
- Requests during busy are ignored: no gnt is issued, and the requester keeps req high.
- A requester dropping req before its grant is legal; no grant is issued to it.
- rsp_ack outside RESP is ignored.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The in-flight request is lost and no response is issued.
- Arithmetic: this block does no arithmetic; the product is signed 16-bit from the datapath.

Test Plan:
- Reset, then req0 with a0=3, b0=5, ack held high -> gnt0 at cycle 0; exactly 8 mul_step cycles; rsp_valid at cycle 12 with rsp_product=0x000F, rsp_id=0.
- req1 with a1=-3 (0xFD), b1=5 -> rsp_product=0xFFF1, rsp_id=1. A second run with a=0x80, b=0x80 -> 0x4000.
- req0 and req1 high simultaneously and continuously, ack held high -> grants alternate 0,1,0,1 starting with 0. Each response's rsp_id matches its grant, with no back-to-back grants to the same requester.
- rsp_ack held low 20 cycles in RESP -> rsp_valid, rsp_product and rsp_id stay stable, and no gnt is issued despite req1=1. On ack, IDLE follows and gnt1 is pulsed.
- Assert rst at cycle 6 of a run -> all outputs 0 immediately and no rsp_valid. After release, a pending req0 is granted with last=1 behaviour.
- Model holds mul_done=0 -> err=1 after CAPTURE and the response is still delivered. err remains set through subsequent operations until rst.
